// File: rtl/banked_blockmem.sv
// Banked line-wide block memory: per-bank write-priority / round-robin-read arbitration plus a clear sweep.
// Reads answer one cycle after grant; requesters wait on rd_ready/wr_ready, which stay low while busy.
module banked_blockmem #(
    parameter int ADDRSIZE  = 1024,
    parameter int BITWIDTH  = 16,
    parameter int LINEWORDS = 4,
    parameter int NUMBANKS  = 4,
    parameter int NRDPORTS  = 3,
    parameter int NWRPORTS  = 2
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NRDPORTS-1:0]                     rd_req,
    input  logic [NRDPORTS*BITWIDTH-1:0]            rd_addr,
    output logic [NRDPORTS-1:0]                     rd_ready,
    output logic [NRDPORTS-1:0]                     rd_rsp_valid,
    output logic [NRDPORTS*LINEWORDS*BITWIDTH-1:0]  rd_rsp_data,
    input  logic [NWRPORTS-1:0]                     wr_req,
    input  logic [NWRPORTS*BITWIDTH-1:0]            wr_addr,
    input  logic [NWRPORTS*LINEWORDS*BITWIDTH-1:0]  wr_data,
    output logic [NWRPORTS-1:0]                     wr_ready,
    input  logic                                    clear_req,
    output logic                                    busy
);

    localparam int LINEW = LINEWORDS * BITWIDTH;
    localparam int LWB   = $clog2(LINEWORDS);
    localparam int NBB   = $clog2(NUMBANKS);
    localparam int ROWS  = ADDRSIZE / (LINEWORDS * NUMBANKS);
    localparam int ROWB  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BANKB = (NUMBANKS > 1) ? NBB : 1;
    localparam int PTRB  = (NRDPORTS > 1) ? $clog2(NRDPORTS) : 1;
    localparam int WCHB  = (NWRPORTS > 1) ? $clog2(NWRPORTS) : 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    // Lines are interleaved across banks: consecutive lines land in consecutive banks.
    function automatic logic [BANKB-1:0] f_bank(input logic [BITWIDTH-1:0] a);
        logic [BITWIDTH-1:0] line;
        line   = (a & BITWIDTH'(ADDRSIZE - 1)) >> LWB;
        f_bank = BANKB'(line & BITWIDTH'(NUMBANKS - 1));
    endfunction

    function automatic logic [ROWB-1:0] f_row(input logic [BITWIDTH-1:0] a);
        logic [BITWIDTH-1:0] line;
        line  = (a & BITWIDTH'(ADDRSIZE - 1)) >> LWB;
        f_row = ROWB'(line >> NBB);
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROWB-1:0]    r_cnt;
    logic [ROWB-1:0]    w_cnt_nxt;
    logic               w_idle;

    logic [LINEW-1:0]   r_mem [NUMBANKS][ROWS];
    logic [PTRB-1:0]    r_rr_ptr [NUMBANKS];
    logic               r_rsp_vld [NRDPORTS];
    logic [LINEW-1:0]   r_rsp_dat [NRDPORTS];

    logic [BANKB-1:0]   w_rd_bank [NRDPORTS];
    logic [ROWB-1:0]    w_rd_row  [NRDPORTS];
    logic [BANKB-1:0]   w_wr_bank [NWRPORTS];
    logic [ROWB-1:0]    w_wr_row  [NWRPORTS];
    logic [LINEW-1:0]   w_wr_dat  [NWRPORTS];

    logic               w_wr_win_vld [NUMBANKS];
    logic [WCHB-1:0]    w_wr_win_ch  [NUMBANKS];
    logic               w_rd_win_vld [NUMBANKS];
    logic [PTRB-1:0]    w_rd_win_ch  [NUMBANKS];
    logic [PTRB-1:0]    w_rr_nxt     [NUMBANKS];
    logic               w_bank_wr_go [NUMBANKS];
    logic               w_bank_rd_go [NUMBANKS];
    logic [ROWB-1:0]    w_bank_wr_row [NUMBANKS];
    logic [LINEW-1:0]   w_bank_wr_dat [NUMBANKS];

    assign w_idle = (r_state == S_IDLE);
    assign busy   = (r_state == S_CLEAR);

    always_comb begin
        for (int r = 0; r < NRDPORTS; r++) begin
            w_rd_bank[r] = f_bank(rd_addr[r*BITWIDTH +: BITWIDTH]);
            w_rd_row[r]  = f_row(rd_addr[r*BITWIDTH +: BITWIDTH]);
        end
        for (int w = 0; w < NWRPORTS; w++) begin
            w_wr_bank[w] = f_bank(wr_addr[w*BITWIDTH +: BITWIDTH]);
            w_wr_row[w]  = f_row(wr_addr[w*BITWIDTH +: BITWIDTH]);
            w_wr_dat[w]  = wr_data[w*LINEW +: LINEW];
        end
    end

    always_comb begin
        rd_ready = '0;
        wr_ready = '0;
        for (int b = 0; b < NUMBANKS; b++) begin
            w_wr_win_vld[b]  = 1'b0;
            w_wr_win_ch[b]   = '0;
            w_rd_win_vld[b]  = 1'b0;
            w_rd_win_ch[b]   = '0;
            w_rr_nxt[b]      = '0;
            w_bank_wr_row[b] = '0;
            w_bank_wr_dat[b] = '0;

            // Descending scan so the lowest-index write channel is the one left standing.
            for (int w = NWRPORTS - 1; w >= 0; w--) begin
                if (wr_req[w] && (w_wr_bank[w] == BANKB'(b))) begin
                    w_wr_win_vld[b]  = 1'b1;
                    w_wr_win_ch[b]   = WCHB'(w);
                    w_bank_wr_row[b] = w_wr_row[w];
                    w_bank_wr_dat[b] = w_wr_dat[w];
                end
            end

            for (int k = 0; k < NRDPORTS; k++) begin
                int idx;
                idx = (int'(r_rr_ptr[b]) + k) % NRDPORTS;
                if (!w_rd_win_vld[b] && rd_req[idx] && (w_rd_bank[idx] == BANKB'(b))) begin
                    w_rd_win_vld[b] = 1'b1;
                    w_rd_win_ch[b]  = PTRB'(idx);
                    w_rr_nxt[b]     = PTRB'((idx + 1) % NRDPORTS);
                end
            end

            w_bank_wr_go[b] = w_idle && w_wr_win_vld[b];
            w_bank_rd_go[b] = w_idle && !w_wr_win_vld[b] && w_rd_win_vld[b];
            if (w_bank_wr_go[b]) begin
                wr_ready[w_wr_win_ch[b]] = 1'b1;
            end
            if (w_bank_rd_go[b]) begin
                rd_ready[w_rd_win_ch[b]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == ROWB'(ROWS - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge clock) begin
        for (int b = 0; b < NUMBANKS; b++) begin
            if (r_state == S_CLEAR) begin
                r_mem[b][r_cnt] <= '0;
            end else if (w_bank_wr_go[b]) begin
                r_mem[b][w_bank_wr_row[b]] <= w_bank_wr_dat[b];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUMBANKS; b++) begin
                r_rr_ptr[b] <= '0;
            end
            for (int r = 0; r < NRDPORTS; r++) begin
                r_rsp_vld[r] <= 1'b0;
                r_rsp_dat[r] <= '0;
            end
        end else begin
            for (int b = 0; b < NUMBANKS; b++) begin
                if (w_bank_rd_go[b]) begin
                    r_rr_ptr[b] <= w_rr_nxt[b];
                end
            end
            for (int r = 0; r < NRDPORTS; r++) begin
                r_rsp_vld[r] <= rd_ready[r];
                if (rd_ready[r]) begin
                    r_rsp_dat[r] <= r_mem[w_rd_bank[r]][w_rd_row[r]];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NRDPORTS; r++) begin
            rd_rsp_valid[r]                  = r_rsp_vld[r];
            rd_rsp_data[r*LINEW +: LINEW]    = r_rsp_dat[r];
        end
    end

endmodule

// File: tb/tb_banked_blockmem.sv
// Directed bench for banked_blockmem: vector table for arbitration/data, hand sequences for sweep and reset.
module tb_banked_blockmem;

    logic           clock;
    logic           reset;
    logic [2:0]     rd_req;
    logic [47:0]    rd_addr;
    logic [2:0]     rd_ready;
    logic [2:0]     rd_rsp_valid;
    logic [191:0]   rd_rsp_data;
    logic [1:0]     wr_req;
    logic [31:0]    wr_addr;
    logic [127:0]   wr_data;
    logic [1:0]     wr_ready;
    logic           clear_req;
    logic           busy;

    int checks = 0;
    int errors = 0;

    banked_blockmem dut (
        .clock        (clock),
        .reset        (reset),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ready     (rd_ready),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .clear_req    (clear_req),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  rq;
        logic [15:0] ra0, ra1, ra2;
        logic [1:0]  wq;
        logic [15:0] wa0, wa1;
        logic [63:0] wd0, wd1;
        logic [2:0]  e_rrdy;
        logic [1:0]  e_wrdy;
        logic [2:0]  e_vld;
        int          dch;
        logic [63:0] e_dat;
    } vec_t;

    localparam logic [63:0] L0 = 64'h0;
    localparam logic [63:0] L1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] L2 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] L3 = 64'hFFFF_8000_7FFF_1234;
    localparam logic [63:0] L4 = 64'hA5A5_0F0F_00FF_C3C3;
    localparam logic [63:0] LF = 64'h7FFF_7FFF_7FFF_7FFF;
    localparam int NV = 14;

    vec_t vt [NV];

    function automatic vec_t mk(input logic [2:0] rq, input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [1:0] wq, input logic [15:0] w0,
                                input logic [15:0] w1, input logic [63:0] d0, input logic [63:0] d1,
                                input logic [2:0] err, input logic [1:0] ewr, input logic [2:0] evld,
                                input int dch, input logic [63:0] edat);
        vec_t v;
        v.rq = rq; v.ra0 = a0; v.ra1 = a1; v.ra2 = a2;
        v.wq = wq; v.wa0 = w0; v.wa1 = w1; v.wd0 = d0; v.wd1 = d1;
        v.e_rrdy = err; v.e_wrdy = ewr; v.e_vld = evld; v.dch = dch; v.e_dat = edat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
    endtask

    // Count sweep cycles: samples (1 time unit after each edge) that still see busy.
    task automatic sweep_len(input int pulse_at, output int n, output int bad);
        n = 1;
        bad = 0;
        while (busy && n < 200) begin
            #1;
            if (rd_ready != 3'b000 || wr_ready != 2'b00) bad++;
            clear_req = (n == pulse_at);
            @(posedge clock); #1;
            if (busy) n++;
        end
        idle_inputs();
    endtask

    initial begin
        int n;
        int bad;
        idle_inputs();
        reset = 1'b0;

        vt[0]  = mk(3'b001, 16'h03FC, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, L0, L0, 3'b001, 2'b00, 3'b001, 0, L0);
        vt[1]  = mk(3'b111, 16'h0000, 16'h0010, 16'h0020, 2'b00, 16'h0, 16'h0, L0, L0, 3'b001, 2'b00, 3'b001, 0, L0);
        vt[2]  = mk(3'b111, 16'h0004, 16'h0010, 16'h0020, 2'b00, 16'h0, 16'h0, L0, L0, 3'b011, 2'b00, 3'b011, 1, L0);
        vt[3]  = mk(3'b100, 16'h0000, 16'h0000, 16'h0020, 2'b00, 16'h0, 16'h0, L0, L0, 3'b100, 2'b00, 3'b100, 2, L0);
        vt[4]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'h0012, 16'h0, L1, L0, 3'b000, 2'b01, 3'b000, -1, L0);
        vt[5]  = mk(3'b001, 16'h0010, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, L0, L0, 3'b001, 2'b00, 3'b001, 0, L1);
        vt[6]  = mk(3'b001, 16'h0410, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, L0, L0, 3'b001, 2'b00, 3'b001, 0, L1);
        vt[7]  = mk(3'b001, 16'h0018, 16'h0, 16'h0, 2'b11, 16'h0008, 16'h0018, L2, L3, 3'b000, 2'b01, 3'b000, -1, L0);
        vt[8]  = mk(3'b001, 16'h0018, 16'h0, 16'h0, 2'b10, 16'h0000, 16'h0018, L0, L3, 3'b000, 2'b10, 3'b000, -1, L0);
        vt[9]  = mk(3'b001, 16'h0018, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, L0, L0, 3'b001, 2'b00, 3'b001, 0, L3);
        vt[10] = mk(3'b100, 16'h0000, 16'h0000, 16'h0008, 2'b00, 16'h0, 16'h0, L0, L0, 3'b100, 2'b00, 3'b100, 2, L2);
        vt[11] = mk(3'b010, 16'h0000, 16'h0012, 16'h0000, 2'b01, 16'h000C, 16'h0, L4, L0, 3'b010, 2'b01, 3'b010, 1, L1);
        vt[12] = mk(3'b011, 16'h03FC, 16'h000C, 16'h0000, 2'b00, 16'h0, 16'h0, L0, L0, 3'b010, 2'b00, 3'b010, 1, L4);
        vt[13] = mk(3'b001, 16'h03FC, 16'h0000, 16'h0000, 2'b00, 16'h0, 16'h0, L0, L0, 3'b001, 2'b00, 3'b001, 0, L0);

        // Reset values and the power-on sweep length.
        #2;
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_rsp_valid", 64'(rd_rsp_valid), 64'd0);
        chk("reset_rsp_data0", rd_rsp_data[63:0], L0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        chk("release_busy", 64'(busy), 64'd1);
        sweep_len(-1, n, bad);
        chk("init_sweep_len", 64'(n), 64'd64);

        for (int i = 0; i < NV; i++) begin
            rd_req  = vt[i].rq;
            rd_addr = {vt[i].ra2, vt[i].ra1, vt[i].ra0};
            wr_req  = vt[i].wq;
            wr_addr = {vt[i].wa1, vt[i].wa0};
            wr_data = {vt[i].wd1, vt[i].wd0};
            #4;
            chk($sformatf("v%0d_rd_ready", i), 64'(rd_ready), 64'(vt[i].e_rrdy));
            chk($sformatf("v%0d_wr_ready", i), 64'(wr_ready), 64'(vt[i].e_wrdy));
            @(posedge clock); #1;
            chk($sformatf("v%0d_rsp_valid", i), 64'(rd_rsp_valid), 64'(vt[i].e_vld));
            if (vt[i].dch >= 0)
                chk($sformatf("v%0d_rsp_data", i), rd_rsp_data[vt[i].dch*64 +: 64], vt[i].e_dat);
        end
        idle_inputs();

        // Write 0x100, confirm it, then clear with a second ignored request mid-sweep.
        wr_req = 2'b01; wr_addr = {16'h0, 16'h0100}; wr_data = {L0, LF};
        #4 chk("c_wr_ready", 64'(wr_ready), 64'd1);
        @(posedge clock); #1;
        idle_inputs();
        rd_req = 3'b001; rd_addr = {32'h0, 16'h0100};
        #4 chk("c_pre_rd_ready", 64'(rd_ready), 64'd1);
        @(posedge clock); #1;
        chk("c_pre_rd_data", rd_rsp_data[63:0], LF);
        idle_inputs();
        clear_req = 1'b1;
        @(posedge clock); #1;
        clear_req = 1'b0;
        chk("c_busy_start", 64'(busy), 64'd1);
        rd_req = 3'b111; rd_addr = {16'h0100, 16'h0010, 16'h0000};
        wr_req = 2'b11; wr_addr = {16'h0004, 16'h0100}; wr_data = {L4, LF};
        sweep_len(10, n, bad);
        chk("c_sweep_len", 64'(n), 64'd64);
        chk("c_no_ready_in_sweep", 64'(bad), 64'd0);
        rd_req = 3'b001; rd_addr = {32'h0, 16'h0100};
        #4 chk("c_post_rd_ready", 64'(rd_ready), 64'd1);
        @(posedge clock); #1;
        chk("c_post_rd_valid", 64'(rd_rsp_valid), 64'd1);
        chk("c_post_rd_data", rd_rsp_data[63:0], L0);
        idle_inputs();

        // Reset while a read response is in flight.
        wr_req = 2'b01; wr_addr = {16'h0, 16'h0012}; wr_data = {L0, L1};
        @(posedge clock); #1;
        idle_inputs();
        rd_req = 3'b001; rd_addr = {32'h0, 16'h0012};
        #4 chk("r_rd_ready", 64'(rd_ready), 64'd1);
        @(posedge clock); #1;
        chk("r_rsp_before_reset", 64'(rd_rsp_valid), 64'd1);
        chk("r_data_before_reset", rd_rsp_data[63:0], L1);
        idle_inputs();
        #1 reset = 1'b0;
        #1;
        chk("r_rsp_dropped", 64'(rd_rsp_valid), 64'd0);
        chk("r_data_reset", rd_rsp_data[63:0], L0);
        chk("r_busy_immediate", 64'(busy), 64'd1);
        @(posedge clock); #1;
        chk("r_rsp_stays_low", 64'(rd_rsp_valid), 64'd0);
        reset = 1'b1;
        sweep_len(-1, n, bad);
        chk("r_sweep_len", 64'(n), 64'd64);
        rd_req = 3'b001; rd_addr = {32'h0, 16'h0012};
        @(posedge clock); #1;
        chk("r_post_data", rd_rsp_data[63:0], L0);
        chk("r_post_valid", 64'(rd_rsp_valid), 64'd1);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
